// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared arbitration policy type and channel-count bounds for stream_arb_mux
package stream_arb_pkg;
    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
    localparam int STREAM_ARB_MIN_CH = 2;
    localparam int STREAM_ARB_MAX_CH = 16;
endpackage

// File: rtl/stream_arb_mux_arb_pick.sv
// arb_pick: combinational first-set search over a request vector, from a start index (RR) or index 0 (fixed)
module arb_pick
    import stream_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_start,
    input  arb_mode_e        i_mode,
    output logic [N_CH-1:0]  o_gnt,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);
    logic [SEL_W-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_pos = SEL_W'((i_mode == ARB_RR) ? (int'(i_start) + k) % N_CH : k);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end
endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N-channel arbitrated registered stream mux; STREAM_ARB_LOCK_EN adds i_last/o_last packet locking
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter int        N_CH     = 4,
    parameter int        WIDTH    = 32,
    parameter arb_mode_e ARB_MODE = ARB_RR,
    parameter int        SEL_W    = $clog2(N_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CH-1:0]       i_valid,
    output logic [N_CH-1:0]       o_ready,
    input  logic [N_CH*WIDTH-1:0] i_data,
`ifdef STREAM_ARB_LOCK_EN
    input  logic [N_CH-1:0]       i_last,
    output logic                  o_last,
`endif
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [SEL_W-1:0]      o_sel,
    input  logic                  i_ready
);
    if (N_CH < STREAM_ARB_MIN_CH || N_CH > STREAM_ARB_MAX_CH) begin : g_bad_n_ch
        $error("stream_arb_mux: N_CH out of range");
    end

    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_gnt;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] w_data;
    logic             w_any;
    logic             w_load;
    logic             w_fire;
    logic             w_last;

`ifdef STREAM_ARB_LOCK_EN
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_ch;
    logic [N_CH-1:0]  w_lock_mask;

    // a locked packet masks every other channel, even while its owner is idle
    assign w_lock_mask = N_CH'(1) << r_lock_ch;
    assign w_req       = r_lock ? (i_valid & w_lock_mask) : i_valid;
    assign w_last      = i_last[w_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
            o_last    <= 1'b0;
        end else if (w_fire) begin
            r_lock    <= !w_last;
            r_lock_ch <= w_idx;
            o_last    <= w_last;
        end
    end
`else
    assign w_req  = i_valid;
    assign w_last = 1'b1;
`endif

    arb_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
        .i_req   (w_req),
        .i_start (r_ptr),
        .i_mode  (ARB_MODE),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_load  = !o_valid || i_ready;
    assign w_fire  = w_load && w_any;
    assign o_ready = (w_load && i_rst_n) ? w_gnt : '0;
    assign w_data  = i_data[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            o_valid <= w_any;
            if (w_any) begin
                o_data <= w_data;
                o_sel  <= w_idx;
                if (w_last)
                    r_ptr <= (w_idx == SEL_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed and randomized checks of an RR instance (dut 0) and a fixed-priority instance (dut 1)
module tb_stream_arb_mux;
    import stream_arb_pkg::*;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rdy = 1'b0;
    logic [N-1:0]   vld [2];
    logic [N-1:0]   lst [2];
    logic [N-1:0]   ordy [2];
    logic [N*W-1:0] dat [2];
    logic           ov [2];
    logic [W-1:0]   od [2];
    logic [1:0]     os [2];
`ifdef STREAM_ARB_LOCK_EN
    logic           ol [2];
`endif
    int total = 0;
    int bad = 0;

    logic           m_ov [2];
    logic           m_ol [2];
    logic           m_lock [2];
    logic [W-1:0]   m_od [2];
    int             m_os [2];
    int             m_p [2];
    int             m_lch [2];
    int             g [2];
    logic [N-1:0]   xfer [2];

    always #5 clk = ~clk;

    stream_arb_mux #(.N_CH(N), .WIDTH(W), .ARB_MODE(ARB_RR)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(ordy[0]), .i_data(dat[0]),
`ifdef STREAM_ARB_LOCK_EN
        .i_last(lst[0]), .o_last(ol[0]),
`endif
        .o_valid(ov[0]), .o_data(od[0]), .o_sel(os[0]), .i_ready(rdy)
    );

    stream_arb_mux #(.N_CH(N), .WIDTH(W), .ARB_MODE(ARB_FIXED)) dut_fx (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(ordy[1]), .i_data(dat[1]),
`ifdef STREAM_ARB_LOCK_EN
        .i_last(lst[1]), .o_last(ol[1]),
`endif
        .o_valid(ov[1]), .o_data(od[1]), .o_sel(os[1]), .i_ready(rdy)
    );

    // reference: who should win this cycle, straight from the policy rules (-1 = nobody)
    function automatic int pick(int d);
        if (m_ov[d] && !rdy) return -1;
        if (m_lock[d]) return vld[d][m_lch[d]] ? m_lch[d] : -1;
        for (int k = 0; k < N; k++) begin
            int c = (d == 0) ? (m_p[d] + k) % N : k;
            if (vld[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 0; m_ol[d] = 0; m_lock[d] = 0; m_od[d] = '0;
            m_os[d] = 0; m_p[d] = 0; m_lch[d] = 0;
        end
    endtask

    task automatic model_clock();
        for (int d = 0; d < 2; d++)
            if (!m_ov[d] || rdy) begin
                m_ov[d] = g[d] >= 0;
                if (g[d] >= 0) begin
                    m_od[d]   = dat[d][g[d]*W +: W];
                    m_os[d]   = g[d];
                    m_ol[d]   = lst[d][g[d]];
                    m_lock[d] = !lst[d][g[d]];
                    m_lch[d]  = g[d];
                    if (lst[d][g[d]]) m_p[d] = (g[d] + 1) % N;
                end
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld[0] = '0; vld[1] = '0; lst[0] = '1; lst[1] = '1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        vld[0] = '1; vld[1] = '1; rdy = 1'b1;
        dat[0] = {4{32'hDEADBEEF}}; dat[1] = {4{32'h12345678}};
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total += 4;
            if (ordy[d] !== 4'b0) begin bad++; $display("FAIL reset_ready dut%0d got=%b want=0000", d, ordy[d]); end
            if (ov[d] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d got=%b want=0", d, ov[d]); end
            if (od[d] !== '0) begin bad++; $display("FAIL reset_data dut%0d got=%h want=0", d, od[d]); end
            if (os[d] !== 2'd0) begin bad++; $display("FAIL reset_sel dut%0d got=%0d want=0", d, os[d]); end
        end
        vld[0] = '0; vld[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_all();
        for (int k = 0; k < N; k++) dat[0][k*W +: W] = $urandom;
        vld[0] = '1; rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] want_d;
            #1;
            want_d = dat[0][(i%4)*W +: W];
            total++;
            if (ordy[0] !== 4'(1) << (i % 4)) begin bad++; $display("FAIL rr_ready beat%0d got=%b want=%b", i, ordy[0], 4'(1) << (i % 4)); end
            @(negedge clk);
            #1;
            total += 3;
            if (ov[0] !== 1'b1) begin bad++; $display("FAIL rr_valid beat%0d got=%b want=1", i, ov[0]); end
            if (os[0] !== 2'(i % 4)) begin bad++; $display("FAIL rr_sel beat%0d got=%0d want=%0d", i, os[0], i % 4); end
            if (od[0] !== want_d) begin bad++; $display("FAIL rr_data beat%0d got=%h want=%h", i, od[0], want_d); end
            dat[0][(i%4)*W +: W] = $urandom;
        end
        vld[0] = '0;
        @(negedge clk);
        #1;
        total += 2;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL rr_drain_valid got=%b want=0", ov[0]); end
        if (os[0] !== 2'd3) begin bad++; $display("FAIL rr_drain_sel_hold got=%0d want=3", os[0]); end
    endtask

    task automatic test_fixed();
        for (int k = 0; k < N; k++) dat[1][k*W +: W] = $urandom;
        vld[1] = 4'b1010; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ordy[1] !== 4'b0010) begin bad++; $display("FAIL fixed_ready_ch1 beat%0d got=%b want=0010", i, ordy[1]); end
            @(negedge clk);
            #1;
            total += 2;
            if (os[1] !== 2'd1) begin bad++; $display("FAIL fixed_sel_ch1 beat%0d got=%0d want=1", i, os[1]); end
            if (od[1] !== dat[1][W +: W]) begin bad++; $display("FAIL fixed_data_ch1 beat%0d got=%h want=%h", i, od[1], dat[1][W +: W]); end
        end
        vld[1] = 4'b1000;
        #1;
        total++;
        if (ordy[1] !== 4'b1000) begin bad++; $display("FAIL fixed_ready_ch3 got=%b want=1000", ordy[1]); end
        @(negedge clk);
        #1;
        total += 2;
        if (os[1] !== 2'd3) begin bad++; $display("FAIL fixed_sel_ch3 got=%0d want=3", os[1]); end
        if (od[1] !== dat[1][3*W +: W]) begin bad++; $display("FAIL fixed_data_ch3 got=%h want=%h", od[1], dat[1][3*W +: W]); end
        vld[1] = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        dat[0][2*W +: W] = 32'hA5A5A5A5;
        dat[0][3*W +: W] = $urandom;
        vld[0] = 4'b0100; rdy = 1'b1;
        @(negedge clk);
        vld[0] = 4'b1111; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total += 4;
            if (ordy[0] !== 4'b0) begin bad++; $display("FAIL bp_ready cyc%0d got=%b want=0000", i, ordy[0]); end
            if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_valid cyc%0d got=%b want=1", i, ov[0]); end
            if (od[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bp_data_hold cyc%0d got=%h want=a5a5a5a5", i, od[0]); end
            if (os[0] !== 2'd2) begin bad++; $display("FAIL bp_sel_hold cyc%0d got=%0d want=2", i, os[0]); end
            @(negedge clk);
        end
        rdy = 1'b1;
        #1;
        total++;
        if (ordy[0] !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b want=1000", ordy[0]); end
        @(negedge clk);
        #1;
        total += 3;
        if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_no_bubble got=%b want=1", ov[0]); end
        if (os[0] !== 2'd3) begin bad++; $display("FAIL bp_next_sel got=%0d want=3", os[0]); end
        if (od[0] !== dat[0][3*W +: W]) begin bad++; $display("FAIL bp_next_data got=%h want=%h", od[0], dat[0][3*W +: W]); end
        vld[0] = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [N-1:0] seq_v [4];
        logic [N-1:0] seq_r [4];
        int           seq_s [4];
        seq_v = '{4'b0010, 4'b1000, 4'b0001, 4'b0011};
        seq_r = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
        seq_s = '{1, 3, 0, 1};
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld[0] = seq_v[i];
            #1;
            total++;
            if (ordy[0] !== seq_r[i]) begin bad++; $display("FAIL wrap_ready step%0d got=%b want=%b", i, ordy[0], seq_r[i]); end
            @(negedge clk);
            #1;
            total++;
            if (os[0] !== 2'(seq_s[i])) begin bad++; $display("FAIL wrap_sel step%0d got=%0d want=%0d", i, os[0], seq_s[i]); end
        end
        vld[0] = '0;
        @(negedge clk);
    endtask

`ifdef STREAM_ARB_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] seq_v [6];
        logic         seq_l [6];
        logic [N-1:0] seq_r [6];
        seq_v = '{4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0001};
        seq_l = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        seq_r = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0001};
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vld[0] = seq_v[i];
            lst[0] = {3'b111, 1'b1} & ~(4'b0010 & {4{!seq_l[i]}});
            #1;
            total++;
            if (ordy[0] !== seq_r[i]) begin bad++; $display("FAIL lock_ready step%0d got=%b want=%b", i, ordy[0], seq_r[i]); end
            @(negedge clk);
        end
        vld[0] = '0; lst[0] = '1;
        @(negedge clk);
    endtask
`endif

    task automatic test_random(int n);
        do_reset();
        xfer[0] = '0; xfer[1] = '0;
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < N; k++)
                    if (!vld[d][k] || xfer[d][k]) begin
                        vld[d][k] = $urandom_range(0, 2) != 0;
                        dat[d][k*W +: W] = $urandom;
`ifdef STREAM_ARB_LOCK_EN
                        lst[d][k] = $urandom_range(0, 2) == 0;
`endif
                    end
            rdy = $urandom_range(0, 3) != 0;
            #1;
            for (int d = 0; d < 2; d++) begin
                logic [N-1:0] want_r;
                g[d] = pick(d);
                want_r = (g[d] < 0) ? 4'b0 : 4'(1) << g[d];
                xfer[d] = vld[d] & want_r;
                total += 2;
                if (ordy[d] !== want_r) begin bad++; $display("FAIL rand_ready dut%0d cyc%0d got=%b want=%b", d, i, ordy[d], want_r); end
                if ({ov[d], os[d], od[d]} !== {m_ov[d], 2'(m_os[d]), m_od[d]})
                    begin bad++; $display("FAIL rand_out dut%0d cyc%0d got=%b/%0d/%h want=%b/%0d/%h", d, i, ov[d], os[d], od[d], m_ov[d], m_os[d], m_od[d]); end
`ifdef STREAM_ARB_LOCK_EN
                total++;
                if (m_ov[d] && ol[d] !== m_ol[d]) begin bad++; $display("FAIL rand_last dut%0d cyc%0d got=%b want=%b", d, i, ol[d], m_ol[d]); end
`endif
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        vld[0] = '1; vld[1] = '1; rdy = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total += 2;
            if (ordy[d] !== 4'b0) begin bad++; $display("FAIL midrst_ready dut%0d got=%b want=0000", d, ordy[d]); end
            if ({ov[d], os[d], od[d]} !== '0) begin bad++; $display("FAIL midrst_out dut%0d got=%b/%0d/%h want=0/0/0", d, ov[d], os[d], od[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (ordy[0] !== 4'b0001) begin bad++; $display("FAIL midrst_restart got=%b want=0001", ordy[0]); end
        vld[0] = '0; vld[1] = '0;
        @(negedge clk);
    endtask

    initial begin
        vld[0] = '0; vld[1] = '0; lst[0] = '1; lst[1] = '1;
        dat[0] = '0; dat[1] = '0;
        model_reset();
        test_reset();
        test_rr_all();
        test_fixed();
        test_backpressure();
        test_wrap();
`ifdef STREAM_ARB_LOCK_EN
        test_lock();
`endif
        test_random(300);
        test_reset_mid();
        test_random(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
